serial_addsub: RTL and testbench

Bit-serial two's-complement adder/subtractor. It consumes the two WIDTH-bit operands decoded from the slide switches (x = SW[7:4], y = SW[3:0]) and produces a registered sum or difference. The result is also given as sign plus magnitude, plus an overflow flag, ready for the hex_driver digits (SIGN/OFF/NUM). Operands are captured on a START pulse, processed LSB-first one bit per clock, and DONE is signalled for one cycle.

---
 rtl/serial_addsub_pkg.sv | 31 +++
 rtl/serial_addsub_twos_to_signmag.sv | 26 ++
 rtl/serial_addsub.sv | 156 +++++++++++++++
 tb/tb_serial_addsub.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/serial_addsub_pkg.sv
// ----------------------------------------------------------------------------
// serial_addsub_pkg
//   Shared definitions for the bit-serial two's-complement adder/subtractor:
//   the controller state encoding, the default operand width, the counter
//   width helper and the full-adder carry (majority) function.
// ----------------------------------------------------------------------------
package serial_addsub_pkg;

    // Controller states. Outputs are Moore (registered).
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } state_t;

    // Default operand/result width (slide-switch nibbles).
    localparam int DEFAULT_WIDTH = 4;

    // The bit counter must hold 0 .. WIDTH-1 with one bit of headroom.
    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

    localparam int DEFAULT_CNT_W = cnt_width(DEFAULT_WIDTH);

    // Carry-out of a full adder: majority of the three inputs.
    function automatic logic majority(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/serial_addsub_twos_to_signmag.sv
// ----------------------------------------------------------------------------
// twos_to_signmag
//   Combinational conversion of a two's-complement word into sign plus
//   unsigned magnitude, for the sign and number digits of the hex display.
//
//   Ports:
//     SUM_NEXT  in   WIDTH  two's-complement value to convert
//     NEG       out  1      sign bit (SUM_NEXT MSB)
//     MAG       out  WIDTH  |SUM_NEXT| as unsigned
//
//   The most-negative value has no positive counterpart in WIDTH signed bits,
//   but as an unsigned WIDTH-bit number ~x+1 yields exactly 2^(WIDTH-1),
//   which is the correct magnitude.
// ----------------------------------------------------------------------------
module twos_to_signmag #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] SUM_NEXT,
    output logic             NEG,
    output logic [WIDTH-1:0] MAG
);

    assign NEG = SUM_NEXT[WIDTH-1];
    assign MAG = NEG ? (~SUM_NEXT + WIDTH'(1)) : SUM_NEXT;

endmodule

// File: rtl/serial_addsub.sv
// ----------------------------------------------------------------------------
// serial_addsub
//   Bit-serial two's-complement adder/subtractor. Operands are captured on a
//   START pulse in IDLE, added LSB-first one bit per clock through a single
//   full adder and carry flop, and the result is published (SUM, OVF, NEG,
//   MAG) on the edge that enters FINISH, where DONE is high for one cycle.
//   Subtraction is X + ~Y + 1: Y is inverted at capture and the carry flop is
//   preloaded with 1.
//
//   Ports:
//     CLK    in   1      system clock, rising edge
//     RST_N  in   1      asynchronous active-low reset
//     START  in   1      start request, sampled only in IDLE
//     SUB    in   1      0: X+Y, 1: X-Y (captured with the operands)
//     X      in   WIDTH  operand A, two's complement
//     Y      in   WIDTH  operand B, two's complement
//     BUSY   out  1      high while bits are being processed
//     DONE   out  1      one-cycle pulse, results valid from this cycle
//     SUM    out  WIDTH  result modulo 2^WIDTH
//     OVF    out  1      signed overflow of the last operation
//     NEG    out  1      sign of SUM
//     MAG    out  WIDTH  |SUM| as unsigned
// ----------------------------------------------------------------------------
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic             SUB,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] SUM,
    output logic             OVF,
    output logic             NEG,
    output logic [WIDTH-1:0] MAG
);

    localparam int               CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    // Controller and datapath state
    state_t           state_q;
    logic [WIDTH-1:0] a_sr_q;
    logic [WIDTH-1:0] b_sr_q;
    logic [WIDTH-1:0] r_sr_q;
    logic             carry_q;
    logic [CNT_W-1:0] cnt_q;

    // Registered outputs
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] sum_q;
    logic             ovf_q;
    logic             neg_q;
    logic [WIDTH-1:0] mag_q;

    // One full-adder slice per clock
    logic             sum_bit_d;
    logic             carry_d;
    logic [WIDTH-1:0] r_sr_d;
    logic             neg_d;
    logic [WIDTH-1:0] mag_d;

    always_comb begin
        sum_bit_d = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
        carry_d   = majority(a_sr_q[0], b_sr_q[0], carry_q);
        // Result bits enter at the MSB so that after WIDTH shifts the first
        // (LSB) result bit has reached position 0.
        r_sr_d    = {sum_bit_d, r_sr_q[WIDTH-1:1]};
    end

    // Sign/magnitude of the result as it will be after the final shift, so
    // that NEG/MAG are registered on the same edge as SUM.
    twos_to_signmag #(
        .WIDTH (WIDTH)
    ) u_signmag (
        .SUM_NEXT (r_sr_d),
        .NEG      (neg_d),
        .MAG      (mag_d)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            r_sr_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            ovf_q   <= 1'b0;
            neg_q   <= 1'b0;
            mag_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (START) begin
                        a_sr_q  <= X;
                        b_sr_q  <= SUB ? ~Y : Y;
                        // Carry-in of 1 completes the ~Y+1 negation.
                        carry_q <= SUB;
                        r_sr_q  <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end

                SHIFT: begin
                    carry_q <= carry_d;
                    r_sr_q  <= r_sr_d;
                    a_sr_q  <= a_sr_q >> 1;
                    b_sr_q  <= b_sr_q >> 1;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        // MSB slice: overflow is carry-into-MSB xor carry-out.
                        sum_q   <= r_sr_d;
                        ovf_q   <= carry_q ^ carry_d;
                        neg_q   <= neg_d;
                        mag_q   <= mag_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= FINISH;
                    end
                end

                FINISH: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end

                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign BUSY = busy_q;
    assign DONE = done_q;
    assign SUM  = sum_q;
    assign OVF  = ovf_q;
    assign NEG  = neg_q;
    assign MAG  = mag_q;

endmodule

// File: tb/tb_serial_addsub.sv
// ----------------------------------------------------------------------------
// tb_serial_addsub
//   Directed bench for serial_addsub (WIDTH = 4) with hand-computed results.
//   Inputs are driven on the falling edge, outputs sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_serial_addsub;

    localparam int W = 4;

    logic         CLK;
    logic         RST_N;
    logic         START;
    logic         SUB;
    logic [W-1:0] X;
    logic [W-1:0] Y;
    logic         BUSY;
    logic         DONE;
    logic [W-1:0] SUM;
    logic         OVF;
    logic         NEG;
    logic [W-1:0] MAG;

    int checks = 0;
    int errors = 0;

    serial_addsub #(.WIDTH(W)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .START (START),
        .SUB   (SUB),
        .X     (X),
        .Y     (Y),
        .BUSY  (BUSY),
        .DONE  (DONE),
        .SUM   (SUM),
        .OVF   (OVF),
        .NEG   (NEG),
        .MAG   (MAG)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Full operation starting at a falling edge. Operands are scrambled after
    // the capture edge so that only the captured copies can produce the result.
    task automatic do_op(input string tag, input logic [W-1:0] xi, input logic [W-1:0] yi,
                         input logic sb, input logic [W-1:0] e_sum, input logic e_ovf,
                         input logic e_neg, input logic [W-1:0] e_mag);
        X = xi; Y = yi; SUB = sb; START = 1'b1;
        @(negedge CLK);
        START = 1'b0; X = ~xi; Y = ~yi; SUB = ~sb;
        for (int i = 0; i < W; i++) begin
            check({tag, "_busy"}, 8'(BUSY), 8'd1);
            check({tag, "_nodone"}, 8'(DONE), 8'd0);
            @(negedge CLK);
        end
        check({tag, "_done"}, 8'(DONE), 8'd1);
        check({tag, "_busy_lo"}, 8'(BUSY), 8'd0);
        check({tag, "_sum"}, 8'(SUM), 8'(e_sum));
        check({tag, "_ovf"}, 8'(OVF), 8'(e_ovf));
        check({tag, "_neg"}, 8'(NEG), 8'(e_neg));
        check({tag, "_mag"}, 8'(MAG), 8'(e_mag));
        @(negedge CLK);
        check({tag, "_done_1cyc"}, 8'(DONE), 8'd0);
        check({tag, "_sum_hold"}, 8'(SUM), 8'(e_sum));
    endtask

    initial begin
        RST_N = 1'b1; START = 1'b0; SUB = 1'b0; X = '0; Y = '0;
        #3 RST_N = 1'b0;
        #1;
        check("rst_busy", 8'(BUSY), 8'd0);
        check("rst_done", 8'(DONE), 8'd0);
        check("rst_sum", 8'(SUM), 8'd0);
        check("rst_ovf", 8'(OVF), 8'd0);
        check("rst_neg", 8'(NEG), 8'd0);
        check("rst_mag", 8'(MAG), 8'd0);
        @(negedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);

        do_op("add_3_2",    4'b0011, 4'b0010, 1'b0, 4'b0101, 1'b0, 1'b0, 4'b0101);
        do_op("add_m3_m2",  4'b1101, 4'b1110, 1'b0, 4'b1011, 1'b0, 1'b1, 4'b0101);
        do_op("add_ovf",    4'b0111, 4'b0001, 1'b0, 4'b1000, 1'b1, 1'b1, 4'b1000);
        do_op("sub_ovf",    4'b1000, 4'b0001, 1'b1, 4'b0111, 1'b1, 1'b0, 4'b0111);
        do_op("sub_2_5",    4'b0010, 4'b0101, 1'b1, 4'b1101, 1'b0, 1'b1, 4'b0011);
        do_op("sub_min_min",4'b1000, 4'b1000, 1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000);

        // START re-pulsed during SHIFT must be ignored.
        X = 4'b0011; Y = 4'b0010; SUB = 1'b0; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        check("repulse_busy", 8'(BUSY), 8'd1);
        X = 4'b0111; Y = 4'b0111; SUB = 1'b1; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        check("repulse_nodone", 8'(DONE), 8'd0);
        @(negedge CLK);
        check("repulse_done", 8'(DONE), 8'd1);
        check("repulse_sum", 8'(SUM), 8'h5);
        @(negedge CLK);
        check("repulse_idle_done", 8'(DONE), 8'd0);
        check("repulse_idle_busy", 8'(BUSY), 8'd0);
        @(negedge CLK);
        check("repulse_no_retrig", 8'(BUSY), 8'd0);

        // START held high: back-to-back operations, one every 6 cycles.
        X = 4'b0001; Y = 4'b0001; SUB = 1'b0; START = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK);
            check($sformatf("held_done_%0d", i), 8'(DONE), ((i == 4) || (i == 10)) ? 8'd1 : 8'd0);
            check($sformatf("held_busy_%0d", i), 8'(BUSY),
                  ((i <= 3) || ((i >= 6) && (i <= 9))) ? 8'd1 : 8'd0);
            if (i == 6) START = 1'b0;
        end
        check("held_sum", 8'(SUM), 8'h2);

        // Reset asserted during the second SHIFT cycle.
        X = 4'b0111; Y = 4'b0011; SUB = 1'b0; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        @(posedge CLK);
        #2 RST_N = 1'b0;
        #1;
        check("mid_rst_busy", 8'(BUSY), 8'd0);
        check("mid_rst_done", 8'(DONE), 8'd0);
        check("mid_rst_sum", 8'(SUM), 8'd0);
        check("mid_rst_ovf", 8'(OVF), 8'd0);
        check("mid_rst_neg", 8'(NEG), 8'd0);
        check("mid_rst_mag", 8'(MAG), 8'd0);
        @(posedge CLK);
        #2 RST_N = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            check($sformatf("post_rst_done_%0d", i), 8'(DONE), 8'd0);
            check($sformatf("post_rst_busy_%0d", i), 8'(BUSY), 8'd0);
        end
        do_op("after_rst", 4'b0110, 4'b1101, 1'b0, 4'b0011, 1'b0, 1'b0, 4'b0011);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
